// File: rtl/fadd_pipe.sv
// Three-stage pipelined floating-point adder (unpack/align, add/normalise, round/pack).
// Define FADD_PIPE_SUB_EN to add the op port (op=1 computes x1 - x2).
module fadd_pipe #(
  parameter int unsigned EW   = 8,
  parameter int unsigned MW   = 23,
  parameter int unsigned TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [EW+MW:0]  x1,
  input  logic [EW+MW:0]  x2,
`ifdef FADD_PIPE_SUB_EN
  input  logic            op,
`endif
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EW+MW:0]  y,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);
  localparam int unsigned W  = 1 + EW + MW;
  localparam int unsigned FW = MW + 4;  // {carry, hidden, mantissa, 2 guard bits}
  localparam int unsigned LW = $clog2(FW) + 1;
  localparam int unsigned XW = EW + LW + 1;
  localparam logic [XW-1:0] EMax = XW'((2 ** EW) - 1);

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Stage 1: unpack and align
  logic [EW-1:0] e1, e2, big_e, diff;
  logic [MW-1:0] m1, m2;
  logic          x2_sign, swap, sign_d;
  logic [FW-1:0] f1, f2, big_f, small_f;

  always_comb begin
    e1 = x1[W-2:MW];
    e2 = x2[W-2:MW];
    m1 = (e1 == '0) ? '0 : x1[MW-1:0];
    m2 = (e2 == '0) ? '0 : x2[MW-1:0];
`ifdef FADD_PIPE_SUB_EN
    x2_sign = x2[W-1] ^ op;
`else
    x2_sign = x2[W-1];
`endif
    f1   = {1'b0, |e1, m1, 2'b00};
    f2   = {1'b0, |e2, m2, 2'b00};
    swap = {e2, m2} > {e1, m1};
    if (swap) begin
      big_e  = e2;
      diff   = e2 - e1;
      big_f  = f2;
      sign_d = x2_sign;
    end else begin
      big_e  = e1;
      diff   = e1 - e2;
      big_f  = f1;
      sign_d = x1[W-1];
    end
    // Shifts of MW+3 or more all yield zero, so no explicit saturation is needed.
    small_f = (swap ? f1 : f2) >> diff;
  end

  logic            st1_valid_q, st1_sign_q, st1_sub_q;
  logic [EW-1:0]   st1_exp_q;
  logic [FW-1:0]   st1_big_q, st1_small_q;
  logic [TAGW-1:0] st1_tag_q;

  // Stage 2: add/subtract and normalise
  logic [FW-1:0] sum, shl;
  logic [LW-1:0] lz;
  logic [MW+2:0] norm_d;
  logic [XW-1:0] exp2_d;

  always_comb begin
    sum = st1_sub_q ? (st1_big_q - st1_small_q) : (st1_big_q + st1_small_q);
    lz  = '0;
    for (int i = 0; i < int'(FW) - 1; i++) begin
      if (sum[i]) lz = LW'(int'(FW) - 2 - i);
    end
    shl = sum << lz;
    if (sum[FW-1]) begin
      norm_d = sum[FW-1:1];
      exp2_d = XW'(st1_exp_q) + XW'(1);
    end else begin
      norm_d = shl[FW-2:0];
      exp2_d = XW'(st1_exp_q) - XW'(lz);
    end
  end

  logic            st2_valid_q, st2_sign_q;
  logic [XW-1:0]   st2_exp_q;
  logic [MW+2:0]   st2_man_q;
  logic [TAGW-1:0] st2_tag_q;

  // Stage 3: round half up on the first dropped bit, then pack with range handling
  logic [MW+1:0] rnd;
  logic [XW-1:0] exp3;
  logic [W-1:0]  y_d;

  always_comb begin
    rnd  = {1'b0, st2_man_q[MW+2:2]} + (MW+2)'(st2_man_q[1]);
    exp3 = st2_exp_q + XW'(rnd[MW+1]);
    if (!(rnd[MW+1] | rnd[MW])) begin
      y_d = '0;
    end else if (exp3[XW-1] || exp3 == '0) begin
      y_d = {st2_sign_q, {(W-1){1'b0}}};
    end else if (exp3 >= EMax) begin
      y_d = {st2_sign_q, {EW{1'b1}}, {MW{1'b0}}};
    end else begin
      y_d = {st2_sign_q, exp3[EW-1:0], rnd[MW-1:0]};
    end
  end

  logic            out_valid_q;
  logic [W-1:0]    y_q;
  logic [TAGW-1:0] out_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st1_valid_q <= 1'b0;
      st2_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      st1_valid_q <= in_valid;
      st2_valid_q <= st1_valid_q;
      out_valid_q <= st2_valid_q;
      if (st2_valid_q) begin
        y_q       <= y_d;
        out_tag_q <= st2_tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      st1_sign_q  <= sign_d;
      st1_sub_q   <= x1[W-1] ^ x2_sign;
      st1_exp_q   <= big_e;
      st1_big_q   <= big_f;
      st1_small_q <= small_f;
      st1_tag_q   <= in_tag;
      st2_sign_q  <= st1_sign_q;
      st2_exp_q   <= exp2_d;
      st2_man_q   <= norm_d;
      st2_tag_q   <= st1_tag_q;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{shl[FW-1], st2_man_q[0]};

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign out_tag   = out_tag_q;
  assign busy      = st1_valid_q | st2_valid_q | out_valid_q;

endmodule

// File: tb/tb_fadd_pipe.sv
// Scoreboard bench for fadd_pipe: driver pushes expected {tag, y}, monitor pops on transfer.
module tb_fadd_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        op = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic [3:0]  out_tag;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_q[$];

  fadd_pipe #(.EW(8), .MW(23), .TAGW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
`ifdef FADD_PIPE_SUB_EN
    .op        (op),
`endif
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Inputs change at negedge+1; everything is sampled at negedge+3.
  task automatic slot();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                      input logic [3:0] t, input logic [31:0] e);
    int n = 0;
    in_valid = 1'b1;
    x1 = a;
    x2 = b;
    op = o;
    in_tag = t;
    #2;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for tag %h, required 1", t);
    end else begin
      exp_q.push_back({t, e});
    end
    slot();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      slot();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic        prev_stall = 1'b0;
  logic [31:0] prev_y;
  logic [3:0]  prev_tag;
  logic [35:0] e;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_y", y, prev_y);
        check("stall_tag", {28'b0, out_tag}, {28'b0, prev_tag});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got y=%h tag=%h, required no output", y, out_tag);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("y_tag%0h", e[35:32]), y, e[31:0]);
          check("out_tag", {28'b0, out_tag}, {28'b0, e[35:32]});
        end
      end
      if (out_valid && !out_ready) begin
        check("in_ready_stall", {31'b0, in_ready}, 32'd0);
        prev_stall = 1'b1;
        prev_y     = y;
        prev_tag   = out_tag;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  logic [31:0] va[6] = '{32'h3FC00000, 32'h3F800000, 32'h7F000000,
                         32'h00800000, 32'h00000000, 32'h40000000};
  logic [31:0] vb[6] = '{32'hBFC00000, 32'h33800000, 32'h7F000000,
                         32'h80C00000, 32'h40490FDB, 32'hBF000000};
  logic [31:0] vy[6] = '{32'h00000000, 32'h3F800001, 32'h7F800000,
                         32'h80000000, 32'h40490FDB, 32'h3FC00000};

  initial begin
    int n;
    slot();
    slot();
    rst = 1'b0;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_y", y, 32'h0);
    check("rst_out_tag", {28'b0, out_tag}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    slot();

    // Latency: out_valid must appear exactly three cycles after accept
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'h5, 32'h40000000);
    n = 0;
    #2;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("latency_extra_cycles", n, 2);
    slot();

    // Back-to-back directed vectors
    for (int i = 0; i < 6; i++) send(va[i], vb[i], 1'b0, 4'(i + 6), vy[i]);
    send(32'h40400000, 32'hBF800000, 1'b0, 4'hC, 32'h40000000);
    drain();

    // Backpressure: fill the pipe, hold the output, then release
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'h1, 32'h40000000);
    send(32'h40000000, 32'hBF000000, 1'b0, 4'h2, 32'h3FC00000);
    send(32'h3F800000, 32'h33800000, 1'b0, 4'h3, 32'h3F800001);
    fork
      send(32'h3FC00000, 32'hBFC00000, 1'b0, 4'h4, 32'h00000000);
      begin
        repeat (5) slot();
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'hA, 32'h40000000);
    send(32'h7F000000, 32'h7F000000, 1'b0, 4'hB, 32'h7F800000);
    send(32'h3F800000, 32'h33800000, 1'b0, 4'hD, 32'h3F800001);
    check("busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    slot();
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    #2;
    check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_y", y, 32'h0);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    slot();
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'hE, 32'h40000000);
`ifdef FADD_PIPE_SUB_EN
    send(32'h40400000, 32'h3F800000, 1'b1, 4'hF, 32'h40000000);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fadd_pipe.md
# fadd_pipe

Pipelined, parametrised floating-point adder/subtractor for the FPU datapath. Sits beside the single-cycle single-precision adder as its next generation. Accepts one operand pair per cycle under a valid/ready handshake and returns results in order after a fixed 3-stage latency. Supports generic exponent/mantissa widths, a passthrough tag, and defined zero/underflow/overflow handling.

## Interface
- EW, 8, exponent width in bits
- MW, 23, stored mantissa width in bits; word width W = 1+EW+MW
- TAGW, 4, width of the opaque tag carried alongside each operation
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts the pair this cycle
- x1, x2  in  W  operands, {sign, exponent, mantissa}
- op  in  1  0 = x1+x2, 1 = x1−x2 (present only with FADD_PIPE_SUB_EN)
- in_tag  in  TAGW  returned unchanged with the result
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result
- y  out  W  result
- out_tag  out  TAGW  tag of the result
- busy  out  1  any stage holds a valid operation

## Operation
- Stage 1 (unpack/align): exponent 0 → operand is zero (hidden bit 0). Select larger-magnitude operand by exponent, then mantissa; result sign = its sign (sign of x2 inverted first when op=1). Extend mantissas to {01, m, 2 guard bits}; right-shift the smaller by the exponent difference, saturated at MW+3.
- Stage 2 (add/normalise): add if effective signs match, else subtract. Carry-out → shift right 1, exponent+1. Otherwise leading-one detect and left-shift, exponent minus shift count.
- Stage 3 (round/pack): round-half-up on the first dropped bit; mantissa carry-out → exponent+1.
- Zero mantissa result → y = 0x…0 (+0, exponent 0).
- Exponent result ≤ 0 → flush to signed zero (exponent 0, mantissa 0).
- Exponent result ≥ 2^EW−1 → signed infinity (exponent all-ones, mantissa 0).
- No NaN/infinity input semantics; all-ones exponents are treated as ordinary values.

## Timing
- Latency exactly 3 cycles from accept (in_valid & in_ready) to out_valid with no stall.
- Global advance: adv = !out_valid | out_ready. in_ready = adv. All stage registers load only when adv=1; bubbles are not collapsed.
- Throughput 1 op/cycle when out_ready held high.
- out_valid, y, out_tag held stable while out_valid & !out_ready.
- Input accepted and output taken in the same cycle are both legal.
- Reset: all stage valid bits, out_valid, busy → 0; y and out_tag → 0. Reset mid-operation discards every in-flight operation; in_ready = 1 in the cycle after reset deasserts.
- busy = OR of the three stage valid bits.

## Configuration
- FADD_PIPE_SUB_EN defined: op port exists; op=1 inverts the x2 sign at stage 1, registered with the operation.
- Undefined: no op port; every operation is x1+x2 and subtraction needs a pre-negated x2.

## Test plan
- EW=8, MW=23: x1=0x3F800000, x2=0x3F800000, op=0 → y=0x40000000 three cycles after accept, out_tag = in_tag.
- x1=0x3FC00000, x2=0xBFC00000 → y=0x00000000; x1=0x3F800000, x2=0x33800000 → y=0x3F800001 (round half up).
- x1=0x7F000000, x2=0x7F000000 → y=0x7F800000; x1=0x00800000, x2=0x80C00000 → y=0x80000000 (underflow flush).
- Issue 4 ops with tags 1..4, hold out_ready=0 for 5 cycles → in_ready=0 while full, y stable, then outputs in tag order 1,2,3,4 with no loss or duplication.
- Assert rst for one cycle with 3 ops in flight → next cycle out_valid=0, busy=0, y=0; a new op then completes normally.
- With FADD_PIPE_SUB_EN: x1=0x40400000, x2=0x3F800000, op=1 → y=0x40000000.
